enc_bin2gray_arb: RTL and testbench
===================================

ENC_BIN2GRAY_ARB -- requirements
Module: enc_bin2gray_arb

Interface
REQ-001 Parameter WIDTH, default 12, SHALL set the code width in bits of every binary and Gray data port.
REQ-002 Parameter NREQ, default 4, SHALL set the number of requesters sharing the converter (legal range 2..16).
REQ-003 Localparam IDW = clog2(NREQ) SHALL set the requester-ID width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-006 req_valid  input  NREQ  SHALL carry the per-requester request-valid bits.
REQ-007 req_bin  input  NREQ*WIDTH  SHALL carry the flattened binary operands; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 req_ready  output  NREQ  SHALL be the one-hot (or zero) grant/accept per requester.
REQ-009 out_valid  output  1  SHALL be high while the result register holds an unconsumed result.
REQ-010 out_ready  input  1  SHALL be the downstream consume strobe.
REQ-011 out_gray  output  WIDTH  SHALL be the registered Gray code of the accepted operand.
REQ-012 out_bin  output  WIDTH  SHALL echo the accepted binary operand.
REQ-013 out_id  output  IDW  SHALL carry the index of the requester that produced the result.
REQ-014 conv_cnt  output  16  SHALL count accepted conversions.

Function
REQ-015 accept_en SHALL equal (!out_valid || out_ready): the result register is empty or is being drained in the same cycle.
REQ-016 Arbitration SHALL be round-robin: search starts at rr_ptr, ascending with wrap past NREQ-1 to 0; the first requester with req_valid set wins.
REQ-017 req_ready[i] SHALL be high combinationally only when accept_en is high and requester i wins; at most one bit set; all zero when no req_valid.
REQ-018 A handshake SHALL complete on a cycle with req_valid[i] && req_ready[i]; requesters hold req_valid and req_bin stable until that cycle.
REQ-019 On a handshake, the next edge SHALL load out_gray = b ^ (b >> 1) (logical shift), out_bin = b, out_id = i, and set out_valid; latency is one cycle.
REQ-020 On a handshake with winner i, rr_ptr SHALL update to (i+1) mod NREQ; with no handshake rr_ptr holds.
REQ-021 out_valid && out_ready with no new handshake SHALL clear out_valid next edge; out_gray, out_bin and out_id hold their last values.
REQ-022 Simultaneous drain and accept SHALL produce back-to-back results (one per cycle); out_valid stays high.
REQ-023 While out_valid && !out_ready, req_ready SHALL be all zero and out_gray, out_bin, out_id SHALL remain stable.
REQ-024 conv_cnt SHALL increment by 1 per handshake and wrap 0xFFFF -> 0x0000.
REQ-025 The state machine SHALL be two states: EMPTY (out_valid=0) and FULL (out_valid=1). EMPTY->FULL on handshake. FULL->EMPTY on out_ready without handshake. FULL->FULL on stall or drain+accept.

Reset
REQ-026 Assertion of rst_n low SHALL immediately force out_valid=0, out_gray=0, out_bin=0, out_id=0, conv_cnt=0, rr_ptr=0 and state EMPTY, including mid-transfer; a pending result is discarded.
REQ-027 While rst_n is low, req_ready SHALL be all zero.
REQ-028 After rst_n deasserts, the first grant SHALL go to the lowest-index valid requester.

Verification
REQ-029 Single request: WIDTH=12, req_valid=4'b0001, req_bin[0]=0xA5A, out_ready=1 -> req_ready=0001 in that cycle; next cycle out_valid=1, out_gray=0xF77, out_bin=0xA5A, out_id=0, conv_cnt=1.
REQ-030 Boundary values: requester 2 sends 0x000, then 0xFFF -> out_gray 0x000, then 0x800; out_id=2.
REQ-031 Fairness: all four req_valid held high, out_ready=1, operands 1, 2, 3, 4 -> grants in order 0, 1, 2, 3, 0; out_gray 0x001, 0x003, 0x002, 0x006; one result per cycle.
REQ-032 Backpressure: out_ready=0 for 3 cycles after the first result -> out_* stable, req_ready=0; on out_ready=1 the next grant goes to the next requester in round-robin order with no lost or duplicated result.
REQ-033 Reset mid-operation: rst_n pulled low while out_valid=1 and out_ready=0 -> out_valid=0 and conv_cnt=0 asynchronously; after release the first grant goes to requester 0.
REQ-034 Counter wrap: 65536 handshakes -> conv_cnt returns to 0x0000.

Source files
------------

// File: rtl/enc_bin2gray_arb.sv
// enc_bin2gray_arb
//   Shared binary-to-Gray converter. NREQ requesters compete for a single
//   result register through a round-robin arbiter; the winner's operand is
//   converted and registered one cycle after its handshake.
//
// Ports
//   clk        in   1           rising-edge clock
//   rst_n      in   1           asynchronous active-low reset
//   req_valid  in   NREQ        per-requester request valid
//   req_bin    in   NREQ*WIDTH  flattened operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready  out  NREQ        one-hot (or zero) grant/accept
//   out_valid  out  1           result register holds an unconsumed result
//   out_ready  in   1           downstream consume strobe
//   out_gray   out  WIDTH       Gray code of the accepted operand
//   out_bin    out  WIDTH       accepted binary operand
//   out_id     out  IDW         index of the requester that produced the result
//   conv_cnt   out  16          accepted-conversion counter (wraps)
module enc_bin2gray_arb #(
  parameter int WIDTH = 12,
  parameter int NREQ  = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_bin,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_gray,
  output logic [WIDTH-1:0]      out_bin,
  output logic [IDW-1:0]        out_id,
  output logic [15:0]           conv_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDW-1:0]     r_rr_ptr;
  logic [WIDTH-1:0]   r_gray_p1;
  logic [WIDTH-1:0]   r_bin_p1;
  logic [IDW-1:0]     r_id_p1;
  logic [15:0]        r_cnt;

  logic               w_accept_en;
  logic               w_found;
  logic [IDW-1:0]     w_win;
  logic [IDW-1:0]     w_idx;
  logic               w_hs;
  logic [NREQ-1:0]    w_req_ready;
  logic [WIDTH-1:0]   w_bin_p0;
  logic [IDW-1:0]     w_ptr_nxt;

  function automatic logic [WIDTH-1:0] f_bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign out_valid   = (r_state == FULL);
  assign w_accept_en = !out_valid || out_ready;

  // Round-robin search: first valid requester at or after r_rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = IDW'((int'(r_rr_ptr) + k) % NREQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // rst_n gates the grant so nothing is accepted while reset is held.
  assign w_hs = w_found && w_accept_en && rst_n;

  always_comb begin
    w_req_ready = '0;
    if (w_hs) w_req_ready[w_win] = 1'b1;
  end

  assign req_ready = w_req_ready;
  assign w_bin_p0  = req_bin[w_win*WIDTH +: WIDTH];
  assign w_ptr_nxt = (w_win == IDW'(NREQ-1)) ? '0 : w_win + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_hs) w_state_nxt = FULL;
      FULL:    if (out_ready && !w_hs) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // p0 -> p1: handshake loads the result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= EMPTY;
      r_rr_ptr  <= '0;
      r_gray_p1 <= '0;
      r_bin_p1  <= '0;
      r_id_p1   <= '0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hs) begin
        r_rr_ptr  <= w_ptr_nxt;
        r_gray_p1 <= f_bin2gray(w_bin_p0);
        r_bin_p1  <= w_bin_p0;
        r_id_p1   <= w_win;
        r_cnt     <= r_cnt + 16'd1;
      end
    end
  end

  assign out_gray = r_gray_p1;
  assign out_bin  = r_bin_p1;
  assign out_id   = r_id_p1;
  assign conv_cnt = r_cnt;

endmodule

// File: tb/tb_enc_bin2gray_arb.sv
module tb_enc_bin2gray_arb;

  localparam int W   = 12;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_bin;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_gray;
  logic [W-1:0]   out_bin;
  logic [IDW-1:0] out_id;
  logic [15:0]    conv_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  enc_bin2gray_arb #(.WIDTH(W), .NREQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_bin   (req_bin),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gray  (out_gray),
    .out_bin   (out_bin),
    .out_id    (out_id),
    .conv_cnt  (conv_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_bin(input int i, input logic [W-1:0] v);
    req_bin[i*W +: W] = v;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_bin   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (out_gray !== 12'h000) begin n_fail++; $display("FAIL rst_out_gray got=%h exp=000", out_gray); end
    n_tests++; if (out_bin !== 12'h000)  begin n_fail++; $display("FAIL rst_out_bin got=%h exp=000", out_bin); end
    n_tests++; if (out_id !== 2'd0)      begin n_fail++; $display("FAIL rst_out_id got=%0d exp=0", out_id); end
    n_tests++; if (conv_cnt !== 16'h0)   begin n_fail++; $display("FAIL rst_conv_cnt got=%h exp=0000", conv_cnt); end
    n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_req_ready got=%b exp=0000", req_ready); end
    req_valid = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    req_valid = 4'b0001;
    set_bin(0, 12'hA5A);
    out_ready = 1'b1;
    #1;
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    n_tests++; if (out_valid !== 1'b1)   begin n_fail++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    n_tests++; if (out_gray !== 12'hF77) begin n_fail++; $display("FAIL single_gray got=%h exp=f77", out_gray); end
    n_tests++; if (out_bin !== 12'hA5A)  begin n_fail++; $display("FAIL single_bin got=%h exp=a5a", out_bin); end
    n_tests++; if (out_id !== 2'd0)      begin n_fail++; $display("FAIL single_id got=%0d exp=0", out_id); end
    n_tests++; if (conv_cnt !== 16'd1)   begin n_fail++; $display("FAIL single_cnt got=%0d exp=1", conv_cnt); end
    tick();
    n_tests++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
    n_tests++; if (out_gray !== 12'hF77) begin n_fail++; $display("FAIL drain_gray_hold got=%h exp=f77", out_gray); end
  endtask

  task automatic test_boundary;
    req_valid = 4'b0100;
    set_bin(2, 12'h000);
    #1;
    n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bnd0_ready got=%b exp=0100", req_ready); end
    tick();
    n_tests++; if (out_gray !== 12'h000 || out_id !== 2'd2 || out_valid !== 1'b1)
      begin n_fail++; $display("FAIL bnd0_out got gray=%h id=%0d v=%b exp gray=000 id=2 v=1", out_gray, out_id, out_valid); end
    set_bin(2, 12'hFFF);
    #1;
    n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bnd1_ready got=%b exp=0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    n_tests++; if (out_gray !== 12'h800 || out_bin !== 12'hFFF || out_id !== 2'd2)
      begin n_fail++; $display("FAIL bnd1_out got gray=%h bin=%h id=%0d exp gray=800 bin=fff id=2", out_gray, out_bin, out_id); end
    n_tests++; if (conv_cnt !== 16'd3) begin n_fail++; $display("FAIL bnd_cnt got=%0d exp=3", conv_cnt); end
    tick();
  endtask

  task automatic test_fairness;
    logic [IDW-1:0] exp_id   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [W-1:0]   exp_gray [5] = '{12'h001, 12'h003, 12'h002, 12'h006, 12'h001};
    logic [N-1:0]   exp_rdy;
    pulse_reset();
    set_bin(0, 12'd1);
    set_bin(1, 12'd2);
    set_bin(2, 12'd3);
    set_bin(3, 12'd4);
    out_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int i = 0; i < 5; i++) begin
      exp_rdy = '0;
      exp_rdy[exp_id[i]] = 1'b1;
      n_tests++; if (req_ready !== exp_rdy)
        begin n_fail++; $display("FAIL fair_ready[%0d] got=%b exp=%b", i, req_ready, exp_rdy); end
      tick();
      n_tests++; if (out_valid !== 1'b1 || out_id !== exp_id[i] || out_gray !== exp_gray[i] || conv_cnt !== 16'(i+1))
        begin n_fail++; $display("FAIL fair_out[%0d] got v=%b id=%0d gray=%h cnt=%0d exp v=1 id=%0d gray=%h cnt=%0d",
                                 i, out_valid, out_id, out_gray, conv_cnt, exp_id[i], exp_gray[i], i+1); end
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (req_ready !== 4'b0000)
        begin n_fail++; $display("FAIL bp_ready[%0d] got=%b exp=0000", i, req_ready); end
      tick();
      n_tests++; if (out_valid !== 1'b1 || out_id !== 2'd0 || out_gray !== 12'h001 || conv_cnt !== 16'd5)
        begin n_fail++; $display("FAIL bp_hold[%0d] got v=%b id=%0d gray=%h cnt=%0d exp v=1 id=0 gray=001 cnt=5",
                                 i, out_valid, out_id, out_gray, conv_cnt); end
    end
    out_ready = 1'b1;
    #1;
    n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_resume_ready got=%b exp=0010", req_ready); end
    tick();
    req_valid = 4'b0000;
    n_tests++; if (out_valid !== 1'b1 || out_id !== 2'd1 || out_gray !== 12'h003 || conv_cnt !== 16'd6)
      begin n_fail++; $display("FAIL bp_resume_out got v=%b id=%0d gray=%h cnt=%0d exp v=1 id=1 gray=003 cnt=6",
                               out_valid, out_id, out_gray, conv_cnt); end
    tick();
  endtask

  task automatic test_reset_mid;
    req_valid = 4'b0001;
    set_bin(0, 12'h123);
    out_ready = 1'b0;
    tick();
    req_valid = 4'b1111;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || conv_cnt !== 16'd0 || out_gray !== 12'h000)
      begin n_fail++; $display("FAIL mid_async got v=%b cnt=%0d gray=%h exp v=0 cnt=0 gray=000", out_valid, conv_cnt, out_gray); end
    n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_ready got=%b exp=0000", req_ready); end
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant got=%b exp=0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    n_tests++; if (out_id !== 2'd0 || out_gray !== 12'h1B2 || conv_cnt !== 16'd1)
      begin n_fail++; $display("FAIL mid_first_out got id=%0d gray=%h cnt=%0d exp id=0 gray=1b2 cnt=1", out_id, out_gray, conv_cnt); end
    tick();
  endtask

  task automatic test_counter_wrap;
    pulse_reset();
    req_valid = 4'b0001;
    set_bin(0, 12'h005);
    out_ready = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    n_tests++; if (conv_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_max got=%h exp=ffff", conv_cnt); end
    tick();
    n_tests++; if (conv_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero got=%h exp=0000", conv_cnt); end
    req_valid = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
